fir_feeder: RTL and testbench
=============================

FIR_FEEDER -- requirements
Module: fir_feeder

Interface
REQ-001 Parameters, one per line:
  WIDTH = 16; sample width in bits; integer multiple of 8.
  LENGTH = 64; FIR tap count.
  TIMEOUT = LENGTH + 8; maximum WAIT cycles.
REQ-002 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port byte_in, input, 8 bits: received UART byte.
REQ-005 Port byte_valid, input, 1 bit: byte_in valid this cycle; single-cycle strobe.
REQ-006 Port fir_data, output, WIDTH bits: sample presented to the FIR.
REQ-007 Port fir_valid, output, 1 bit: one-cycle start strobe to the FIR.
REQ-008 Port fir_done, input, 1 bit: FIR result-valid pulse.
REQ-009 Port busy, output, 1 bit: high while in ISSUE or WAIT.
REQ-010 Port overrun, output, 1 bit: sticky error, a completed sample was dropped.
REQ-011 Port timeout, output, 1 bit: sticky error, fir_done was not seen within TIMEOUT cycles.
REQ-012 Port sample_cnt, output, 16 bits: number of samples issued; wraps modulo 2^16.

Function
REQ-013 Assembly: bytes are little-endian; the first byte goes to bits [7:0], and so on up to WIDTH/8 bytes per sample.
REQ-014 Byte index counter: advances only on byte_valid, wraps to 0 after byte WIDTH/8-1, and the cycle of that last byte marks the sample complete.
REQ-015 Pending buffer: one entry. On completion, the sample is written to pending, which becomes full on the next edge.
REQ-016 Overrun: a completion while pending is full and not being drained that cycle drops the new sample and sets overrun; pending keeps the old sample.
REQ-017 Simultaneous drain and completion: when pending is drained by ISSUE entry in the same cycle as a completion, the new sample is written to pending and no overrun is raised.
REQ-018 Issue FSM state IDLE: if pending is full, move to ISSUE, load fir_data from pending, and clear pending.
REQ-019 Issue FSM state ISSUE: assert fir_valid for exactly one cycle, increment sample_cnt, and move to WAIT unconditionally.
REQ-020 Issue FSM state WAIT: clear the wait counter on entry and increment it each cycle; fir_done moves to IDLE; reaching TIMEOUT sets timeout and moves to IDLE.
REQ-021 Latency: the pending-full edge is followed by fir_valid high in the cycle after the IDLE->ISSUE transition, i.e. two edges from the sample-complete cycle with the FSM idle.
REQ-022 fir_done outside WAIT is ignored with no state change; fir_done on the same cycle the timeout count is reached takes priority and timeout is not set.
REQ-023 fir_data holds its value from ISSUE until the next ISSUE.
REQ-024 Byte collection never stalls; byte_valid is accepted in every state.
REQ-025 Flags: overrun and timeout stay high until rst, with no other clear path.

Reset
REQ-026 rst asserted at any time, including mid-sample or in WAIT, forces all of the following immediately without waiting for clk:
  FSM to IDLE;
  byte index, pending-full and wait counter to 0;
  fir_data, fir_valid, busy, overrun, timeout and sample_cnt to 0.
REQ-027 A partial sample in progress at reset is discarded; the first byte after reset is byte 0.

Verification
REQ-028 Basic issue: bytes 0x34, 0x12 with fir_done returned 65 cycles after fir_valid -> fir_valid pulses once with fir_data=0x1234, busy high until fir_done, sample_cnt=1.
REQ-029 Overrun: 6 bytes back-to-back (three samples) while FIR never answers -> first sample issued, second held in pending, third dropped with overrun=1; after fir_done the second sample is issued.
REQ-030 Timeout: fir_done withheld -> timeout=1 exactly TIMEOUT cycles after WAIT entry, FSM returns to IDLE, and a pending sample is issued next.
REQ-031 Collision: the last byte of a new sample arrives in the same cycle pending drains to ISSUE -> new sample lands in pending with overrun=0.
REQ-032 Reset mid-operation: rst asserted after one byte while in WAIT -> all outputs 0 asynchronously; after rst, bytes 0xCD, 0xAB give fir_data=0xABCD.
REQ-033 Stray done: fir_done pulsed in IDLE -> no state change and busy stays 0.

Source files
------------

// File: rtl/fir_feeder.sv
// Byte-to-sample feeder for a FIR core: assembles little-endian UART bytes into
// WIDTH-bit samples, buffers one sample, and hands each to the FIR with a start strobe.
module fir_feeder #(
    parameter int WIDTH   = 16,
    parameter int LENGTH  = 64,
    parameter int TIMEOUT = LENGTH + 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic [WIDTH-1:0] fir_data,
    output logic             fir_valid,
    input  logic             fir_done,
    output logic             busy,
    output logic             overrun,
    output logic             timeout,
    output logic [15:0]      sample_cnt
);
    localparam int NBYTES = WIDTH / 8;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int WCNT_W = $clog2(((TIMEOUT > LENGTH) ? TIMEOUT : LENGTH) + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t              r_state, w_next;
    logic [IDX_W-1:0]    r_byte_idx;
    logic [WIDTH-1:0]    r_asm;
    logic [WIDTH-1:0]    w_sample;
    logic [WIDTH-1:0]    r_pend_data;
    logic                r_pend_full;
    logic [WIDTH-1:0]    r_fir_data;
    logic [15:0]         r_sample_cnt;
    logic [WCNT_W-1:0]   r_wait_cnt;
    logic                r_overrun;
    logic                r_timeout;
    logic                w_complete;
    logic                w_drain;
    logic                w_wait_hit;

    // The sample as it would look with the current byte merged in; the last
    // byte is taken straight from byte_in so completion needs no extra cycle.
    always_comb begin
        w_sample = r_asm;
        for (int b = 0; b < NBYTES; b++) begin
            if (r_byte_idx == IDX_W'(b)) begin
                w_sample[b*8 +: 8] = byte_in;
            end
        end
    end

    assign w_complete = byte_valid && (r_byte_idx == IDX_W'(NBYTES - 1));
    assign w_drain    = (r_state == S_IDLE) && r_pend_full;
    assign w_wait_hit = (r_wait_cnt == WCNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (r_pend_full) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (fir_done || w_wait_hit) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        fir_valid = (r_state == S_ISSUE);
        busy      = (r_state == S_ISSUE) || (r_state == S_WAIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byte_idx   <= '0;
            r_asm        <= '0;
            r_pend_data  <= '0;
            r_pend_full  <= 1'b0;
            r_fir_data   <= '0;
            r_sample_cnt <= '0;
            r_wait_cnt   <= '0;
            r_overrun    <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            if (byte_valid) begin
                r_asm      <= w_sample;
                r_byte_idx <= w_complete ? '0 : r_byte_idx + 1'b1;
            end

            // A drain in the same cycle frees the slot for the arriving sample.
            if (w_complete && (!r_pend_full || w_drain)) begin
                r_pend_data <= w_sample;
                r_pend_full <= 1'b1;
            end else if (w_drain) begin
                r_pend_full <= 1'b0;
            end
            if (w_complete && r_pend_full && !w_drain) begin
                r_overrun <= 1'b1;
            end

            if (w_drain) begin
                r_fir_data <= r_pend_data;
            end

            if (r_state == S_ISSUE) begin
                r_sample_cnt <= r_sample_cnt + 16'd1;
                r_wait_cnt   <= '0;
            end

            // fir_done wins over a timeout reached in the same cycle.
            if ((r_state == S_WAIT) && !fir_done) begin
                if (w_wait_hit) begin
                    r_timeout <= 1'b1;
                end else begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                end
            end
        end
    end

    assign fir_data   = r_fir_data;
    assign overrun    = r_overrun;
    assign timeout    = r_timeout;
    assign sample_cnt = r_sample_cnt;

endmodule

// File: tb/tb_fir_feeder.sv
// Bench for fir_feeder: a cycle-by-cycle vector table for overrun, collision and
// stray-done cases, then hand-written sequences for issue latency, timeout and reset.
module tb_fir_feeder;
    localparam int WIDTH   = 16;
    localparam int LENGTH  = 64;
    localparam int TIMEOUT = LENGTH + 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [7:0]       byte_in = 8'h00;
    logic             byte_valid = 1'b0;
    logic [WIDTH-1:0] fir_data;
    logic             fir_valid;
    logic             fir_done = 1'b0;
    logic             busy;
    logic             overrun;
    logic             timeout;
    logic [15:0]      sample_cnt;

    int n_vec = 0;
    int n_err = 0;

    fir_feeder #(.WIDTH(WIDTH), .LENGTH(LENGTH), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .fir_data   (fir_data),
        .fir_valid  (fir_valid),
        .fir_done   (fir_done),
        .busy       (busy),
        .overrun    (overrun),
        .timeout    (timeout),
        .sample_cnt (sample_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        bv;
        logic [7:0]  b;
        logic        done;
        logic        fv;
        logic [15:0] data;
        logic        busy;
        logic        ov;
        logic        to;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic bv, input logic [7:0] b, input logic d,
                       input logic fv, input logic [15:0] data, input logic bs,
                       input logic ov, input logic to, input logic [15:0] cnt);
        vec_t v;
        v.rst = r; v.bv = bv; v.b = b; v.done = d;
        v.fv = fv; v.data = data; v.busy = bs; v.ov = ov; v.to = to; v.cnt = cnt;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic bv, input logic [7:0] b, input logic d);
        byte_valid = bv;
        byte_in    = b;
        fir_done   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        rst = 1'b0;
    endtask

    task automatic wait_fv(input string nm);
        int k;
        k = 0;
        while (!fir_valid && k < 8) begin
            step(1'b0, 8'h00, 1'b0);
            k++;
        end
        chk(nm, {31'd0, fir_valid}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int e;
        int bad;

        // Reset value, applied asynchronously before any clock edge.
        #1 rst = 1'b1;
        #2;
        chk("reset_fv",   {31'd0, fir_valid}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_data", {16'd0, fir_data}, 32'd0);
        chk("reset_cnt",  {16'd0, sample_cnt}, 32'd0);

        //   rst bv  byte   done  fv data      busy ov to cnt
        add(1, 0, 8'h00, 0,   0, 16'h0000, 0, 0, 0, 16'd0);
        // Three samples back to back, FIR silent until released by hand.
        add(0, 1, 8'h01, 0,   0, 16'h0000, 0, 0, 0, 16'd0);
        add(0, 1, 8'hA1, 0,   0, 16'h0000, 0, 0, 0, 16'd0);
        add(0, 1, 8'h02, 0,   1, 16'hA101, 1, 0, 0, 16'd0);
        add(0, 1, 8'hA2, 0,   0, 16'hA101, 1, 0, 0, 16'd1);
        add(0, 1, 8'h03, 0,   0, 16'hA101, 1, 0, 0, 16'd1);
        add(0, 1, 8'hA3, 0,   0, 16'hA101, 1, 1, 0, 16'd1);
        add(0, 0, 8'h00, 1,   0, 16'hA101, 0, 1, 0, 16'd1);
        add(0, 0, 8'h00, 0,   1, 16'hA202, 1, 1, 0, 16'd1);
        add(0, 0, 8'h00, 0,   0, 16'hA202, 1, 1, 0, 16'd2);
        add(0, 0, 8'h00, 1,   0, 16'hA202, 0, 1, 0, 16'd2);
        add(0, 0, 8'h00, 0,   0, 16'hA202, 0, 1, 0, 16'd2);
        add(1, 0, 8'h00, 0,   0, 16'h0000, 0, 0, 0, 16'd0);
        // Last byte of a sample lands in the cycle pending drains into ISSUE.
        add(0, 1, 8'h11, 0,   0, 16'h0000, 0, 0, 0, 16'd0);
        add(0, 1, 8'h22, 0,   0, 16'h0000, 0, 0, 0, 16'd0);
        add(0, 0, 8'h00, 0,   1, 16'h2211, 1, 0, 0, 16'd0);
        add(0, 1, 8'h33, 0,   0, 16'h2211, 1, 0, 0, 16'd1);
        add(0, 1, 8'h44, 0,   0, 16'h2211, 1, 0, 0, 16'd1);
        add(0, 1, 8'h55, 0,   0, 16'h2211, 1, 0, 0, 16'd1);
        add(0, 0, 8'h00, 1,   0, 16'h2211, 0, 0, 0, 16'd1);
        add(0, 1, 8'h66, 0,   1, 16'h4433, 1, 0, 0, 16'd1);
        add(0, 0, 8'h00, 0,   0, 16'h4433, 1, 0, 0, 16'd2);
        add(0, 0, 8'h00, 1,   0, 16'h4433, 0, 0, 0, 16'd2);
        add(0, 0, 8'h00, 0,   1, 16'h6655, 1, 0, 0, 16'd2);
        add(0, 0, 8'h00, 0,   0, 16'h6655, 1, 0, 0, 16'd3);
        add(0, 0, 8'h00, 1,   0, 16'h6655, 0, 0, 0, 16'd3);
        // Stray fir_done while idle.
        add(0, 0, 8'h00, 1,   0, 16'h6655, 0, 0, 0, 16'd3);
        add(0, 0, 8'h00, 0,   0, 16'h6655, 0, 0, 0, 16'd3);

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst;
            step(tbl[i].bv, tbl[i].b, tbl[i].done);
            chk($sformatf("row%0d_fv", i),   {31'd0, fir_valid}, {31'd0, tbl[i].fv});
            chk($sformatf("row%0d_data", i), {16'd0, fir_data},  {16'd0, tbl[i].data});
            chk($sformatf("row%0d_busy", i), {31'd0, busy},      {31'd0, tbl[i].busy});
            chk($sformatf("row%0d_ov", i),   {31'd0, overrun},   {31'd0, tbl[i].ov});
            chk($sformatf("row%0d_to", i),   {31'd0, timeout},   {31'd0, tbl[i].to});
            chk($sformatf("row%0d_cnt", i),  {16'd0, sample_cnt}, {16'd0, tbl[i].cnt});
        end
        rst = 1'b0;

        // Basic issue with fir_done 65 cycles after the start strobe.
        do_reset();
        step(1'b1, 8'h34, 1'b0);
        chk("basic_no_early_fv", {31'd0, fir_valid}, 32'd0);
        step(1'b1, 8'h12, 1'b0);
        chk("basic_no_early_fv2", {31'd0, fir_valid}, 32'd0);
        step(1'b0, 8'h00, 1'b0);
        chk("basic_latency_fv", {31'd0, fir_valid}, 32'd1);
        chk("basic_data", {16'd0, fir_data}, 32'h1234);
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            step(1'b0, 8'h00, 1'b0);
            if (!busy || fir_valid) bad++;
        end
        chk("basic_busy_hold_errs", bad, 0);
        step(1'b0, 8'h00, 1'b1);
        chk("basic_busy_after_done", {31'd0, busy}, 32'd0);
        chk("basic_cnt", {16'd0, sample_cnt}, 32'd1);
        chk("basic_no_timeout", {31'd0, timeout}, 32'd0);

        // Timeout with a second sample waiting in pending.
        do_reset();
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'h02, 1'b0);
        wait_fv("to_first_fv");
        step(1'b1, 8'h03, 1'b0);
        e = 0;
        while (!timeout && e < 200) begin
            step(e == 0, 8'h04, 1'b0);
            e++;
        end
        chk("to_edges_after_wait_entry", e, TIMEOUT);
        chk("to_busy_after", {31'd0, busy}, 32'd0);
        step(1'b0, 8'h00, 1'b0);
        chk("to_next_fv", {31'd0, fir_valid}, 32'd1);
        chk("to_next_data", {16'd0, fir_data}, 32'h0403);
        chk("to_cnt", {16'd0, sample_cnt}, 32'd1);

        // Reset mid-sample while waiting, asserted between clock edges.
        step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'hEE, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("amid_busy", {31'd0, busy}, 32'd0);
        chk("amid_timeout", {31'd0, timeout}, 32'd0);
        chk("amid_data", {16'd0, fir_data}, 32'd0);
        chk("amid_cnt", {16'd0, sample_cnt}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        step(1'b1, 8'hCD, 1'b0);
        step(1'b1, 8'hAB, 1'b0);
        wait_fv("amid_fv");
        chk("amid_new_data", {16'd0, fir_data}, 32'hABCD);

        // fir_done arriving in the very cycle the timeout count is reached.
        step(1'b0, 8'h00, 1'b0);
        for (int k = 1; k < TIMEOUT; k++) step(1'b0, 8'h00, 1'b0);
        chk("edge_busy_before", {31'd0, busy}, 32'd1);
        step(1'b0, 8'h00, 1'b1);
        chk("edge_timeout", {31'd0, timeout}, 32'd0);
        chk("edge_busy_after", {31'd0, busy}, 32'd0);
        fir_done = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
